// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder that reuses an external 4-bit ripple-carry adder,
// one nibble per cycle from LSB to MSB, with valid/ready on both sides.
module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    op_a_reg;
  logic [W-1:0]    op_b_reg;
  logic            cin_reg;
  logic            carry_reg;
  logic            ovf_c;

  // Adder operand steering: current nibble in RUN, quiet zeros otherwise
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = 4'(op_a_reg >> {idx, 2'b00});
      add_b   = 4'(op_b_reg >> {idx, 2'b00});
      add_cin = (idx == '0) ? cin_reg : carry_reg;
    end
  end

  // Signed overflow: operands share a sign that the top sum nibble does not
  always_comb begin
    ovf_c = (op_a_reg[W-1] == op_b_reg[W-1]) && (add_s[3] != op_a_reg[W-1]);
  end

  // Control FSM plus operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            op_a_reg <= op_a;
            op_b_reg <= op_b;
            cin_reg  <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          in_ready                 <= 1'b0;
          sum[{idx, 2'b00} +: 4]   <= add_s;
          carry_reg                <= add_cout;
          if (idx == LAST_IDX) begin
            cout      <= add_cout;
            ovf       <= ovf_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and random checks of nibble_add_seq with a behavioural 4-bit adder.
module tb_nibble_add_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cin;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // External 4-bit adder
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transaction; returns result, latency in edges and a timeout flag
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int stall, output logic [W-1:0] s, output logic co,
                       output logic ov, output int lat, output bit ok);
    int n;
    ok = 1'b1; s = '0; co = 1'b0; ov = 1'b0; lat = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin ok = 1'b0; return; end
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin ok = 1'b0; return; end
    s = sum; co = cout; ov = ovf;
    repeat (stall) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b sum=%h co=%b ov=%b want all 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 9'd0) begin
      errors++;
      $display("FAIL reset_adder_inputs got %h/%h/%b want 0", add_a, add_b, add_cin);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] vb [7] = '{16'h1111, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    logic         vc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [7] = '{16'h2345, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic         ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], vc[i], i % 3, s, co, ov, lat, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL vec%0d_timeout got no handshake want completion", i);
      end else begin
        if ({co, s, ov} !== {ec[i], es[i], eo[i]}) begin
          errors++;
          $display("FAIL vec%0d_result got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                   i, s, co, ov, es[i], ec[i], eo[i]);
        end
        checks++;
        if (lat != NIBBLES) begin
          errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, NIBBLES);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int n;
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!out_valid) begin
      errors++; $display("FAIL bp_timeout got out_valid=0 want 1");
    end
    held = sum;
    checks++;
    if (held !== 16'h2345) begin
      errors++; $display("FAIL bp_sum got %h want 2345", held);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sum !== 16'h2345 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {add_a, add_b, add_cin} !== 9'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%h rdy=%b vld=%b add=%h/%h/%b want 2345/0/1/0",
                 i, sum, in_ready, out_valid, add_a, add_b, add_cin);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept got rdy=%b want 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL bp_second got sum=%h co=%b ov=%b want 0000/1/0", sum, cout, ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit ok;
    op_a = 16'h7777; op_b = 16'h7777; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b vld=%b sum=%h co=%b ov=%b add=%h/%h/%b want 0",
               in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_ready got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 0, s, co, ov, lat, ok);
    checks++;
    if (!ok || {co, s, ov} !== {1'b0, 16'h0002, 1'b0}) begin
      errors++; $display("FAIL midrst_fresh got ok=%b sum=%h co=%b ov=%b want 0002/0/0", ok, s, co, ov);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic c, co, ov;
    logic [W:0] ref_full;
    int sr;
    logic ref_ovf;
    int lat;
    bit ok;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      ref_full = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
      sr = int'($signed(a)) + int'($signed(b)) + int'(c);
      ref_ovf = (sr > 32767) || (sr < -32768);
      do_op(a, b, c, int'($urandom_range(0, 3)), s, co, ov, lat, ok);
      checks++;
      if (!ok || {co, s} !== ref_full || ov !== ref_ovf) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h c=%b got ok=%b %b_%h ov=%b want %h ov=%b",
                 i, a, b, c, ok, co, s, ov, ref_full, ref_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
